// File: rtl/mmac_pkg.sv
// Shared types and packed-operand layout for the matrix MAC unit.
// Loader and MAC both derive element positions from these definitions.
package mmac_pkg;

    localparam int MMAC_ELEM_W = 8;
    localparam int MMAC_DIM    = 4;

    typedef enum logic [1:0] {
        LOAD_A,
        LOAD_B,
        PRESENT
    } mmac_ld_state_e;

    // Element [0][0] sits in the MSBs; row-major toward the LSBs.
    function automatic int mmac_elem_lsb(input int r, input int c);
        return MMAC_ELEM_W * (MMAC_DIM * MMAC_DIM - 1 - (r * MMAC_DIM + c));
    endfunction

endpackage

// File: rtl/mmac_operand_loader.sv
// Byte-serial operand loader for the matrix MAC unit.
// Assembles A then B from one element stream and presents them packed.
module mmac_operand_loader
    import mmac_pkg::*;
#(
    parameter int ELEM_W = MMAC_ELEM_W,
    parameter int DIM    = MMAC_DIM,
    parameter int ERRC_W = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clear,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [ELEM_W-1:0]         s_data,
    input  logic                      s_last,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [DIM*DIM*ELEM_W-1:0] m_matrix_a,
    output logic [DIM*DIM*ELEM_W-1:0] m_matrix_b,
    output logic                      frame_err,
    output logic [ERRC_W-1:0]         err_cnt
);

    localparam int NELEM = DIM * DIM;
    localparam int NBEAT = 2 * NELEM;
    localparam int MAT_W = NELEM * ELEM_W;
    localparam int CNT_W = $clog2(NBEAT);
    localparam int LSB_W = (MAT_W > 1) ? $clog2(MAT_W) : 1;

    localparam logic [CNT_W-1:0] A_END = CNT_W'(NELEM - 1);
    localparam logic [CNT_W-1:0] B_END = CNT_W'(NBEAT - 1);

    mmac_ld_state_e   state;
    mmac_ld_state_e   state_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    logic             accept;
    logic             err_now;
    logic             wr_a;
    logic             wr_b;
    int               wr_idx;
    logic [LSB_W-1:0] wr_lsb;
    logic [MAT_W-1:0] mat_a;
    logic [MAT_W-1:0] mat_b;

    assign accept = s_valid && s_ready;

    // s_ready is registered from the next state so it is low straight out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= LOAD_A;
            cnt     <= '0;
            s_ready <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            s_ready <= (state_n != PRESENT);
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        err_now = 1'b0;
        if (clear) begin
            state_n = LOAD_A;
            cnt_n   = '0;
        end else begin
            unique case (state)
                LOAD_A: begin
                    if (accept) begin
                        if (s_last) begin
                            err_now = 1'b1;
                            cnt_n   = '0;
                        end else begin
                            cnt_n = cnt + 1'b1;
                            if (cnt == A_END) begin
                                state_n = LOAD_B;
                            end
                        end
                    end
                end
                LOAD_B: begin
                    if (accept) begin
                        if (cnt == B_END) begin
                            cnt_n = '0;
                            if (s_last) begin
                                state_n = PRESENT;
                            end else begin
                                state_n = LOAD_A;
                                err_now = 1'b1;
                            end
                        end else if (s_last) begin
                            state_n = LOAD_A;
                            cnt_n   = '0;
                            err_now = 1'b1;
                        end else begin
                            cnt_n = cnt + 1'b1;
                        end
                    end
                end
                PRESENT: begin
                    if (m_ready) begin
                        state_n = LOAD_A;
                    end
                end
                default: begin
                    state_n = LOAD_A;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    always_comb begin
        m_valid    = (state == PRESENT);
        m_matrix_a = mat_a;
        m_matrix_b = mat_b;
        wr_a       = accept && !clear && (state == LOAD_A);
        wr_b       = accept && !clear && (state == LOAD_B);
        wr_idx     = (state == LOAD_B) ? int'(cnt) - NELEM : int'(cnt);
        wr_lsb     = LSB_W'((NELEM - 1 - wr_idx) * ELEM_W);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mat_a <= '0;
            mat_b <= '0;
        end else begin
            if (wr_a) begin
                mat_a[wr_lsb +: ELEM_W] <= s_data;
            end
            if (wr_b) begin
                mat_b[wr_lsb +: ELEM_W] <= s_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_err <= 1'b0;
            err_cnt   <= '0;
        end else begin
            frame_err <= err_now;
            if (err_now && (err_cnt != '1)) begin
                err_cnt <= err_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mmac_operand_loader.sv
// Self-checking bench for mmac_operand_loader: directed tables plus
// a transaction-level scoreboard watching both handshakes.
module tb_mmac_operand_loader;

    localparam int N  = 16;
    localparam int NB = 32;
    localparam logic [127:0] A_EXP = 128'h0102030405060708090A0B0C0D0E0F10;
    localparam logic [127:0] B_EXP = 128'h01000000000100000000010000000001;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         clear = 1'b0;
    logic         s_valid = 1'b0;
    logic         s_last = 1'b0;
    logic         m_ready = 1'b0;
    logic [7:0]   s_data = 8'h00;
    logic         s_ready;
    logic         m_valid;
    logic         frame_err;
    logic [127:0] m_matrix_a;
    logic [127:0] m_matrix_b;
    logic [7:0]   err_cnt;

    typedef struct packed {
        logic [127:0] a;
        logic [127:0] b;
    } pair_t;

    typedef struct {
        int last_pos;
        bit exp_err;
        bit exp_pres;
    } vec_t;

    int           n_tests = 0;
    int           n_fail = 0;
    int           n_pres = 0;
    int           cyc = 0;
    int           mdl_err = 0;
    bit           pend_err = 1'b0;
    int           rdy_mode = 1;
    pair_t        exp_q[$];
    logic [7:0]   fq[$];
    int           rises[$];
    logic [127:0] last_a = '0;
    logic [127:0] last_b = '0;
    logic [7:0]   frm[NB];
    vec_t         vecs[7];

    mmac_operand_loader dut (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .s_last     (s_last),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_matrix_a (m_matrix_a),
        .m_matrix_b (m_matrix_b),
        .frame_err  (frame_err),
        .err_cnt    (err_cnt)
    );

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Matrix packing: first element ends up in the MSBs.
    function automatic logic [127:0] pack_q(input int base);
        logic [127:0] v = '0;
        for (int i = 0; i < N; i++) v = {v[119:0], fq[base + i]};
        return v;
    endfunction

    function automatic logic [127:0] pack_frm(input int base);
        logic [127:0] v = '0;
        for (int i = 0; i < N; i++) v = {v[119:0], frm[base + i]};
        return v;
    endfunction

    // Scoreboard: frames complete on the 32nd beat with s_last, anything else is an error.
    initial begin
        bit    skip;
        bit    mv_prev;
        pair_t e;
        skip = 1'b1;
        mv_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                fq.delete();
                exp_q.delete();
                mdl_err = 0;
                pend_err = 1'b0;
                skip = 1'b1;
                mv_prev = 1'b0;
            end else begin
                chk("mon_frame_err", 128'(frame_err), 128'(pend_err));
                chk("mon_err_cnt", 128'(err_cnt), 128'(mdl_err));
                chk("mon_m_valid", 128'(m_valid), 128'(exp_q.size() != 0));
                if (!skip) chk("mon_s_ready", 128'(s_ready), 128'(exp_q.size() == 0));
                skip = 1'b0;
                if (m_valid && !mv_prev) rises.push_back(cyc);
                mv_prev = m_valid;
                pend_err = 1'b0;
                if (clear) begin
                    fq.delete();
                    exp_q.delete();
                end else begin
                    if (m_valid && m_ready && exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk("mon_matrix_a", m_matrix_a, e.a);
                        chk("mon_matrix_b", m_matrix_b, e.b);
                        last_a = m_matrix_a;
                        last_b = m_matrix_b;
                        n_pres++;
                    end
                    if (s_valid && s_ready) begin
                        fq.push_back(s_data);
                        if (s_last || fq.size() == NB) begin
                            if (s_last && fq.size() == NB) begin
                                e.a = pack_q(0);
                                e.b = pack_q(N);
                                exp_q.push_back(e);
                            end else begin
                                pend_err = 1'b1;
                                if (mdl_err < 255) mdl_err++;
                            end
                            fq.delete();
                        end
                    end
                end
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        case (rdy_mode)
            0: m_ready = 1'b0;
            1: m_ready = 1'b1;
            2: m_ready = ($urandom_range(3, 0) == 0);
            default: ;
        endcase
    end

    task automatic beat(input logic [7:0] d, input bit last, input int gmax);
        int  w;
        int  g;
        bit  got;
        g = (gmax > 0) ? int'($urandom_range(32'(gmax), 0)) : 0;
        repeat (g) begin
            @(posedge clk);
            #1;
        end
        s_valid = 1'b1;
        s_data = d;
        s_last = last;
        got = 1'b0;
        w = 0;
        while (!got && w < 300) begin
            @(negedge clk);
            got = s_ready;
            @(posedge clk);
            #1;
            w++;
        end
        if (!got) chk("beat_timeout", 128'(got), 128'(1));
        s_valid = 1'b0;
        s_last = 1'b0;
    endtask

    task automatic send_frame(input int last_pos, input int gmax);
        for (int i = 0; i < NB; i++) begin
            beat(frm[i], i == last_pos, gmax);
            if (i == last_pos) break;
        end
    endtask

    task automatic wait_idle();
        int w;
        w = 0;
        while ((exp_q.size() != 0 || m_valid) && w < 1000) begin
            @(negedge clk);
            w++;
        end
        @(posedge clk);
        #1;
        if (w >= 1000) chk("drain_timeout", 128'(w), 128'(0));
    endtask

    task automatic basic_data();
        for (int i = 0; i < N; i++) frm[i] = 8'(i + 1);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) frm[N + r * 4 + c] = (r == c) ? 8'h01 : 8'h00;
    endtask

    task automatic rand_data();
        for (int i = 0; i < NB; i++) frm[i] = 8'($urandom);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n0;
        int exp_cnt;
        vecs[0] = '{20, 1'b1, 1'b0};
        vecs[1] = '{31, 1'b0, 1'b1};
        vecs[2] = '{0,  1'b1, 1'b0};
        vecs[3] = '{32, 1'b1, 1'b0};
        vecs[4] = '{15, 1'b1, 1'b0};
        vecs[5] = '{16, 1'b1, 1'b0};
        vecs[6] = '{31, 1'b0, 1'b1};

        // Reset release, then reset asserted mid-stream
        rdy_mode = 1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("ready_low_at_release", 128'(s_ready), 128'(0));
        @(posedge clk);
        #1;
        chk("ready_after_release", 128'(s_ready), 128'(1));
        basic_data();
        beat(frm[0], 1'b1, 0);
        @(posedge clk);
        #1;
        chk("pre_rst_err_cnt", 128'(err_cnt), 128'(1));
        for (int i = 0; i < 10; i++) beat(frm[i], 1'b0, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_m_valid", 128'(m_valid), 128'(0));
        chk("rst_s_ready", 128'(s_ready), 128'(0));
        chk("rst_err_cnt", 128'(err_cnt), 128'(0));
        chk("rst_frame_err", 128'(frame_err), 128'(0));
        chk("rst_matrix_a", m_matrix_a, 128'(0));
        chk("rst_matrix_b", m_matrix_b, 128'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst2_ready_low", 128'(s_ready), 128'(0));
        @(posedge clk);
        #1;
        chk("rst2_ready_high", 128'(s_ready), 128'(1));

        // Basic frame held under m_ready=0
        rdy_mode = 3;
        m_ready = 1'b0;
        basic_data();
        send_frame(31, 0);
        chk("basic_m_valid_latency", 128'(m_valid), 128'(1));
        chk("basic_matrix_a", m_matrix_a, A_EXP);
        chk("basic_matrix_b", m_matrix_b, B_EXP);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("hold_matrix_a", m_matrix_a, A_EXP);
            chk("hold_matrix_b", m_matrix_b, B_EXP);
            chk("hold_s_ready", 128'(s_ready), 128'(0));
            chk("hold_m_valid", 128'(m_valid), 128'(1));
        end
        @(posedge clk);
        #1;
        m_ready = 1'b1;
        chk("take_m_valid_same_cycle", 128'(m_valid), 128'(1));
        @(posedge clk);
        #1;
        m_ready = 1'b0;
        chk("take_m_valid_drop", 128'(m_valid), 128'(0));
        chk("take_s_ready_rise", 128'(s_ready), 128'(1));

        // Backpressure on both sides
        rdy_mode = 2;
        n0 = n_pres;
        for (int k = 0; k < 4; k++) send_frame(31, 3);
        wait_idle();
        chk("bp_frames", 128'(n_pres - n0), 128'(4));
        chk("bp_matrix_a", last_a, A_EXP);
        chk("bp_matrix_b", last_b, B_EXP);
        n0 = n_pres;
        for (int k = 0; k < 4; k++) begin
            rand_data();
            send_frame(31, 2);
        end
        wait_idle();
        chk("rnd_frames", 128'(n_pres - n0), 128'(4));
        chk("rnd_last_a", last_a, pack_frm(0));
        chk("rnd_last_b", last_b, pack_frm(N));

        // Framing-error table
        rdy_mode = 1;
        exp_cnt = 0;
        for (int k = 0; k < 7; k++) begin
            n0 = n_pres;
            rand_data();
            send_frame(vecs[k].last_pos, 0);
            chk("tbl_frame_err", 128'(frame_err), 128'(vecs[k].exp_err));
            if (vecs[k].exp_err && exp_cnt < 255) exp_cnt++;
            @(posedge clk);
            #1;
            chk("tbl_err_pulse_end", 128'(frame_err), 128'(0));
            repeat (2) begin
                @(posedge clk);
                #1;
            end
            chk("tbl_err_cnt", 128'(err_cnt), 128'(exp_cnt));
            chk("tbl_presented", 128'(n_pres - n0), 128'(vecs[k].exp_pres));
            if (vecs[k].exp_pres) chk("tbl_matrix_a", last_a, pack_frm(0));
        end
        for (int k = 0; k < 260; k++) beat(8'($urandom), 1'b1, 0);
        @(posedge clk);
        #1;
        chk("err_cnt_saturate", 128'(err_cnt), 128'(255));

        // clear while presenting with m_ready low
        rdy_mode = 0;
        rand_data();
        send_frame(31, 0);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        chk("clr_present_m_valid", 128'(m_valid), 128'(0));
        chk("clr_present_s_ready", 128'(s_ready), 128'(1));

        // clear on LOAD_B beat 25, then a fresh frame
        rdy_mode = 1;
        rand_data();
        for (int i = 0; i < 25; i++) beat(frm[i], 1'b0, 0);
        s_valid = 1'b1;
        s_data = frm[25];
        s_last = 1'b0;
        clear = 1'b1;
        @(negedge clk);
        chk("clr_beat_ready", 128'(s_ready), 128'(1));
        @(posedge clk);
        #1;
        clear = 1'b0;
        s_valid = 1'b0;
        n0 = n_pres;
        rand_data();
        send_frame(31, 0);
        wait_idle();
        chk("clr_next_frames", 128'(n_pres - n0), 128'(1));
        chk("clr_next_a", last_a, pack_frm(0));
        chk("clr_next_b", last_b, pack_frm(N));
        chk("clr_err_cnt", 128'(err_cnt), 128'(255));

        // Back-to-back streaming
        rises.delete();
        for (int k = 0; k < 3; k++) begin
            rand_data();
            send_frame(31, 0);
        end
        wait_idle();
        chk("b2b_rises", 128'(rises.size()), 128'(3));
        for (int i = 1; i < rises.size(); i++)
            chk("b2b_period", 128'(rises[i] - rises[i-1]), 128'(33));
        chk("b2b_last_a", last_a, pack_frm(0));
        chk("b2b_last_b", last_b, pack_frm(N));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
